// File: rtl/cpu_core_mc.sv
// Multi-cycle 16-bit-instruction CPU core with req/ack instruction and data ports.
// Define CPU_MUL_EN to turn opcode 12 into MUL; otherwise it is a NOP.
module cpu_core_mc #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int NREGS  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     imem_req,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic                     imem_ack,
  input  logic [15:0]              imem_rdata,
  output logic                     dmem_req,
  output logic                     dmem_we,
  output logic [ADDR_W-1:0]        dmem_addr,
  output logic [DATA_W-1:0]        dmem_wdata,
  input  logic                     dmem_ack,
  input  logic [DATA_W-1:0]        dmem_rdata,
  input  logic [$clog2(NREGS)-1:0] dbg_ra,
  output logic [DATA_W-1:0]        dbg_rd,
  output logic [ADDR_W-1:0]        pc_out,
  output logic [15:0]              instr_out,
  output logic                     retire,
  output logic                     halted
);

  localparam int RW = $clog2(NREGS);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t st, nxt;

  logic [ADDR_W-1:0] pc;
  logic [15:0]       ir;
  logic [DATA_W-1:0] rf [NREGS];
  logic [DATA_W-1:0] a, b, res, alu;
  logic [ADDR_W-1:0] maddr;
  logic [DATA_W-1:0] mwdata;
  logic              mwe;

  logic [3:0]    op;
  logic [RW-1:0] rd, rs1, rs2;
  logic          is_alu, is_ls, is_halt, taken;

  assign op  = ir[15:12];
  assign rd  = ir[8 +: RW];
  assign rs1 = ir[4 +: RW];
  assign rs2 = ir[0 +: RW];

`ifdef CPU_MUL_EN
  assign is_alu = (op <= 4'd7) || (op == 4'd12);
`else
  assign is_alu = (op <= 4'd7);
`endif
  assign is_ls   = (op == 4'd8) || (op == 4'd9);
  assign is_halt = (op == 4'd15);
  assign taken   = (op == 4'd11) || ((op == 4'd10) && (a == '0));

  always_comb begin
    alu = '0;
    case (op)
      4'd0: alu = a + b;
      4'd1: alu = a - b;
      4'd2: alu = a & b;
      4'd3: alu = a | b;
      4'd4: alu = a ^ b;
      4'd5: alu = a << 1;
      4'd6: alu = a >> 1;
      4'd7: alu = DATA_W'(ir[7:0]);
`ifdef CPU_MUL_EN
      4'd12: alu = DATA_W'(a * b);
`endif
      default: alu = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) st <= S_FETCH;
    else        st <= nxt;
  end

  // Strobes are gated by reset so nothing is requested or retired in a reset cycle.
  always_comb begin
    nxt      = st;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    retire   = 1'b0;
    case (st)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) nxt = S_DECODE;
      end
      S_DECODE: nxt = S_EXEC;
      S_EXEC: begin
        unique case (1'b1)
          is_ls:   nxt = S_MEM;
          is_alu:  nxt = S_WB;
          is_halt: nxt = S_HALT;
          default: begin
            retire = 1'b1;
            nxt    = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        if (dmem_ack) begin
          if (mwe) begin
            retire = 1'b1;
            nxt    = S_FETCH;
          end else begin
            nxt = S_WB;
          end
        end
      end
      S_WB: begin
        retire = 1'b1;
        nxt    = S_FETCH;
      end
      S_HALT: nxt = S_HALT;
      default: nxt = S_FETCH;
    endcase
    if (!reset) begin
      imem_req = 1'b0;
      dmem_req = 1'b0;
      retire   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc     <= '0;
      ir     <= '0;
      a      <= '0;
      b      <= '0;
      res    <= '0;
      maddr  <= '0;
      mwe    <= 1'b0;
      mwdata <= '0;
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else begin
      case (st)
        S_FETCH: if (imem_ack) ir <= imem_rdata;
        S_DECODE: begin
          a <= rf[rs1];
          b <= rf[rs2];
        end
        S_EXEC: begin
          res <= alu;
          if (is_ls) begin
            maddr  <= ADDR_W'(a);
            mwe    <= (op == 4'd9);
            mwdata <= b;
          end else if (!is_alu && !is_halt) begin
            pc <= taken ? ADDR_W'(ir[7:0]) : pc + 1'b1;
          end
        end
        S_MEM: begin
          if (dmem_ack) begin
            if (mwe) pc  <= pc + 1'b1;
            else     res <= dmem_rdata;
          end
        end
        S_WB: begin
          rf[rd] <= res;
          pc     <= pc + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign imem_addr  = pc;
  assign pc_out     = pc;
  assign instr_out  = ir;
  assign dmem_we    = mwe;
  assign dmem_addr  = maddr;
  assign dmem_wdata = mwdata;
  assign dbg_rd     = rf[dbg_ra];
  assign halted     = (st == S_HALT) && reset;

endmodule

// File: tb/tb_cpu_core_mc.sv
// Directed bench for cpu_core_mc with wait-state capable memory models.
// Expected values are hand-computed per program.
module tb_cpu_core_mc;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req, imem_ack;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [7:0]  dmem_addr, dmem_wdata, dmem_rdata;
  logic [1:0]  dbg_ra;
  logic [7:0]  dbg_rd, pc_out;
  logic [15:0] instr_out;
  logic        retire, halted;

  cpu_core_mc dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .dbg_ra(dbg_ra), .dbg_rd(dbg_rd),
    .pc_out(pc_out), .instr_out(instr_out),
    .retire(retire), .halted(halted)
  );

  always #5 clk = ~clk;

  logic [15:0] imem [256];
  logic [7:0]  dmem [256];
  int iwait = 0, dwait = 0;
  int icnt = 0, dcnt = 0;
  int excl = 0;

  assign imem_ack   = imem_req && (icnt >= iwait);
  assign imem_rdata = imem[imem_addr];
  assign dmem_ack   = dmem_req && (dcnt >= dwait);
  assign dmem_rdata = dmem[dmem_addr];

  always @(posedge clk) begin
    icnt <= (imem_req && !imem_ack) ? icnt + 1 : 0;
    dcnt <= (dmem_req && !dmem_ack) ? dcnt + 1 : 0;
    if (dmem_req && dmem_ack && dmem_we) dmem[dmem_addr] <= dmem_wdata;
  end

  always @(negedge clk) if (imem_req && dmem_req) excl <= excl + 1;

  int total = 0, bad = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic clr_prog();
    for (int i = 0; i < 256; i++) imem[i] = 16'hF000;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_ireq", imem_req, 0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_pc", pc_out, 0);
    chk("rst_ir", instr_out, 0);
    chk("rst_halt", halted, 0);
    chk("rst_ret", retire, 0);
    chk("rst_dreq", dmem_req, 0);
    chk("rst_dwe", dmem_we, 0);
    chk("rst_dadr", dmem_addr, 0);
    chk("rst_dwd", dmem_wdata, 0);
    reset = 1'b1;
    #1;
  endtask

  task automatic step(string tag, int exp_n);
    int n = 1;
    while (!retire && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk(tag, n, exp_n);
    @(negedge clk);
  endtask

  task automatic rchk(string tag, int r, logic [7:0] e);
    dbg_ra = r[1:0];
    #1;
    chk(tag, dbg_rd, e);
  endtask

  task automatic wait_halt();
    int n = 0;
    while (!halted && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("halt_seen", halted, 1);
  endtask

  initial begin
    int cnt;
    reset  = 1'b0;
    dbg_ra = '0;

    clr_prog();
    imem[0] = 16'h712A;
    do_reset();
    step("ldi_cyc", 4);
    chk("ldi_pc", pc_out, 8'h01);
    rchk("ldi_r1", 1, 8'h2A);

    clr_prog();
    imem[0] = 16'h7105; imem[1] = 16'h7203;
    imem[2] = 16'h1312; imem[3] = 16'h1021;
    do_reset();
    step("ldi1", 4);
    step("ldi2", 4);
    step("sub1", 4);
    step("sub2", 4);
    chk("sub_pc", pc_out, 8'h04);
    wait_halt();
    rchk("sub_r3", 3, 8'h02);
    rchk("sub_r0", 0, 8'hFE);

    clr_prog();
    imem[0] = 16'h71C5; imem[1] = 16'h720F;
    imem[2] = 16'h2312; imem[3] = 16'h3012;
    imem[4] = 16'h4212; imem[5] = 16'h5110;
    imem[6] = 16'h0001; imem[7] = 16'h6330;
    do_reset();
    wait_halt();
    chk("log_pc", pc_out, 8'h08);
    rchk("add_r0", 0, 8'h59);
    rchk("shl_r1", 1, 8'h8A);
    rchk("xor_r2", 2, 8'hCA);
    rchk("shr_r3", 3, 8'h02);

    dwait = 3;
    clr_prog();
    imem[0] = 16'h7105; imem[1] = 16'h7203;
    imem[2] = 16'h9012; imem[3] = 16'h8010;
    do_reset();
    step("m_ldi1", 4);
    step("m_ldi2", 4);
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk("st_req", dmem_req, 1);
      chk("st_we", dmem_we, 1);
      chk("st_adr", dmem_addr, 8'h05);
      chk("st_wd", dmem_wdata, 8'h03);
      chk("st_ret", retire, (k == 3) ? 1 : 0);
      @(negedge clk);
    end
    step("ld_wait", 8);
    rchk("ld_r0", 0, 8'h03);
    dwait = 0;

    clr_prog();
    imem[8'h00] = 16'hA040;
    imem[8'h40] = 16'h7001; imem[8'h41] = 16'hA040;
    imem[8'h42] = 16'h7110; imem[8'h43] = 16'h7211;
    imem[8'h44] = 16'h7377; imem[8'h45] = 16'hB0C0;
    imem[8'hC0] = 16'hC312;
    do_reset();
    step("beqz_t", 3);
    chk("beqz_t_pc", pc_out, 8'h40);
    step("b_ldi", 4);
    step("beqz_nt", 3);
    chk("beqz_nt_pc", pc_out, 8'h42);
    step("b_ldi1", 4);
    step("b_ldi2", 4);
    step("b_ldi3", 4);
    step("jmp", 3);
    chk("jmp_pc", pc_out, 8'hC0);
`ifdef CPU_MUL_EN
    step("mul_cyc", 4);
    rchk("mul_r3", 3, 8'h10);
`else
    step("nop_cyc", 3);
    rchk("nop_r3", 3, 8'h77);
`endif
    wait_halt();
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (imem_req || !halted) cnt++;
    end
    chk("halt_idle", cnt, 0);
    chk("halt_pc", pc_out, 8'hC1);

    dwait = 5;
    clr_prog();
    imem[0] = 16'h7105; imem[1] = 16'h7233;
    imem[2] = 16'h8210;
    do_reset();
    step("r_ldi1", 4);
    step("r_ldi2", 4);
    repeat (3) @(negedge clk);
    chk("mid_req", dmem_req, 1);
    do_reset();
    rchk("abort_r2", 2, 8'h00);
    chk("abort_pc", pc_out, 8'h00);
    dwait = 0;
    step("restart", 4);
    rchk("restart_r1", 1, 8'h05);

    chk("excl", excl, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
